crono_countdown_timer: RTL and testbench
========================================

Name: crono_countdown_timer

Overview:
- Parametrised hh:mm:ss countdown timer.
- Next generation of the single-field hour adjuster: three fields with per-field maxima, selectable wrap or saturate on adjust, and borrow cascading while running.
- Sits between the debounced button / adjust-select logic and the display formatter.
- Field values are set with inc/dec pulses, counted down on an external 1 Hz enable, and expiry is flagged.

Parameters:
- HR_MAX, 23, maximum hour value (legal 1..31)
- MIN_MAX, 59, maximum minute value (legal 1..63)
- SEC_MAX, 59, maximum second value (legal 1..63)
- WRAP_ADJ, 1, 1 = adjust wraps at the limits; 0 = adjust saturates

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sel  in  2  field select: 0 = hours, 1 = minutes, 2 = seconds, 3 = none
- inc  in  1  single-cycle pulse: increment selected field
- dec  in  1  single-cycle pulse: decrement selected field
- start  in  1  pulse: begin or resume countdown
- stop  in  1  pulse: pause countdown / acknowledge alarm
- tick  in  1  1 Hz single-cycle enable
- hr  out  5  hours value
- min  out  6  minutes value
- sec  out  6  seconds value
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse on expiry
- alarm  out  1  high while in EXPIRED

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - hr = min = sec = 0
  - state = SET
  - running = 0, done = 0, alarm = 0
- Reset has priority over all other inputs in any state.
- All outputs are registered and reflect an event on the clock edge after it is sampled.
- States:
  - SET (initial)
  - RUN
  - EXPIRED
- SET:
  - inc/dec act on the field chosen by sel; sel = 3 ignores both.
  - inc and dec in the same cycle: inc wins.
  - WRAP_ADJ = 1: inc at max -> 0; dec at 0 -> max.
  - WRAP_ADJ = 0: inc at max holds; dec at 0 holds.
  - start with nonzero total time -> RUN.
  - start with hr = min = sec = 0 is ignored.
  - tick is ignored.
- RUN:
  - inc/dec are ignored.
  - On tick:
    - sec > 0: sec decrements.
    - sec = 0, min > 0: sec = SEC_MAX, min decrements.
    - sec = min = 0, hr > 0: sec = SEC_MAX, min = MIN_MAX, hr decrements.
  - If a tick takes the total to 00:00:00 -> EXPIRED; done = 1 for exactly the one cycle in which the fields first read zero.
  - stop -> SET with values held (pause).
  - stop beats start and tick in the same cycle; no decrement occurs.
  - start while in RUN has no effect.
- EXPIRED:
  - alarm = 1; fields read zero.
  - Any of start, stop, inc, dec -> SET with alarm cleared.
  - The clearing pulse itself causes no adjust.
- Every state/output transition happens in one clock; there is no multi-cycle latency.
- Field values never exceed their parameter maxima. If a maximum is out of its legal range, behaviour is undefined.

Optional Feature:
- Macro: CRONO_AUTORELOAD_EN.
- Defined:
  - On the SET -> RUN transition, a reload register captures hr/min/sec.
  - On expiry, done still pulses, but the fields reload from the captured value in the same edge.
  - The state stays RUN; EXPIRED and alarm are never entered or asserted.
  - stop still pauses to SET. A subsequent start recaptures the current (paused) values.
- Undefined: no reload register; behaviour exactly as above.

Decomposition:
- Package crono_pkg:
  - state typedef (SET, RUN, EXPIRED)
  - field-select constants FIELD_HR = 0, FIELD_MIN = 1, FIELD_SEC = 2, FIELD_NONE = 3
  - default maxima constants
- One sub-module, crono_field, instantiated three times:
  - parameters: width, max, wrap
  - inputs: inc, dec, borrow_in (countdown step)
  - outputs: value, is_zero, borrow_out (asserted when stepping down at 0, reloading to max)
- The top level holds the FSM, the done/alarm registers and the optional reload register.

Test Plan:
1. Reset, then sel = 0, inc x 24 (WRAP_ADJ = 1) -> hr steps 1..23 then 0; dec once at 0 -> hr = 23.
2. WRAP_ADJ = 0 build: sel = 2, dec at sec = 0 -> sec stays 0; inc x 70 -> sec saturates at 59.
3. Set 00:01:00, start, one tick -> 00:00:59; 59 more ticks -> 00:00:00, done high exactly one cycle, alarm = 1; stop -> alarm = 0, state SET.
4. Set 01:00:00, start, tick -> 00:59:59 (double borrow); stop and tick in the same cycle -> values held, running = 0.
5. start with 00:00:00 -> running stays 0. In RUN, inc with sel = 0 -> no change. Assert rst mid-countdown at 00:00:30 -> all outputs 0 next cycle.
6. CRONO_AUTORELOAD_EN build: set 00:00:02, start, 2 ticks -> done pulse, fields read 00:00:02, running stays 1, alarm = 0.

Source files
------------

// File: rtl/crono_pkg.sv
// Shared types and constants for the hh:mm:ss countdown timer.
// Build option CRONO_AUTORELOAD_EN (see crono_countdown_timer) needs nothing extra here.
package crono_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SET     = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_EXPIRED = 2'd2;

    localparam logic [1:0] FIELD_HR   = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    localparam int HR_MAX_DEF  = 23;
    localparam int MIN_MAX_DEF = 59;
    localparam int SEC_MAX_DEF = 59;

    function automatic logic field_hit(input logic [1:0] sel, input logic [1:0] field);
        return (sel == field);
    endfunction

endpackage

// File: rtl/crono_field.sv
// One time field (hours, minutes or seconds): user adjust, countdown step with
// borrow to the next-higher field, and a parallel load used for auto-reload.
module crono_field
    import crono_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int MAX   = 59,
    parameter bit WRAP  = 1'b1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             borrow_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             is_zero,
    output logic             borrow_out
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_next_s;
    logic             at_max_s;

    assign value      = value_r;
    assign is_zero    = (value_r == ZERO_V);
    assign at_max_s   = (value_r == MAX_V);
    assign borrow_out = borrow_in && is_zero;

    // Next value: load beats countdown, countdown beats adjust, inc beats dec.
    always_comb begin
        value_next_s = value_r;
        if (load) begin
            value_next_s = load_value;
        end else if (borrow_in) begin
            value_next_s = is_zero ? MAX_V : (value_r - ONE_V);
        end else if (inc) begin
            value_next_s = at_max_s ? (WRAP ? ZERO_V : MAX_V) : (value_r + ONE_V);
        end else if (dec) begin
            value_next_s = is_zero ? (WRAP ? MAX_V : ZERO_V) : (value_r - ONE_V);
        end else begin
            value_next_s = value_r;
        end
    end

    // Field register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= ZERO_V;
        end else begin
            value_r <= value_next_s;
        end
    end

endmodule

// File: rtl/crono_countdown_timer.sv
// hh:mm:ss countdown timer: SET/RUN/EXPIRED control around three cascaded fields.
// Optional build macro CRONO_AUTORELOAD_EN: reload the start value on expiry and keep running.
module crono_countdown_timer
    import crono_pkg::*;
#(
    parameter int HR_MAX   = HR_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter bit WRAP_ADJ = 1'b1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    state_t     state_r;
    state_t     state_next_s;
    logic       running_r;
    logic       done_r;
    logic       alarm_r;

    logic       hr_zero_s, min_zero_s, sec_zero_s, total_zero_s;
    logic       sec_borrow_s, min_borrow_s, hr_borrow_s;
    logic       start_ok_s, adj_en_s, tick_step_s, expire_s;
    logic       load_s;
    logic [4:0] hr_load_s;
    logic [5:0] min_load_s;
    logic [5:0] sec_load_s;

    assign total_zero_s = hr_zero_s && min_zero_s && sec_zero_s;
    // Accepted start suppresses a same-cycle adjust so the captured value equals what runs.
    assign start_ok_s   = (state_r == ST_SET) && start && !total_zero_s;
    assign adj_en_s     = (state_r == ST_SET) && !start_ok_s;
    assign tick_step_s  = (state_r == ST_RUN) && tick && !stop;
    assign expire_s     = tick_step_s && hr_zero_s && min_zero_s && (sec == 6'd1);

    assign running = running_r;
    assign done    = done_r;
    assign alarm   = alarm_r;

`ifdef CRONO_AUTORELOAD_EN
    logic [4:0] hr_rel_r;
    logic [5:0] min_rel_r;
    logic [5:0] sec_rel_r;

    // Reload register: captures the displayed time on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            hr_rel_r  <= 5'd0;
            min_rel_r <= 6'd0;
            sec_rel_r <= 6'd0;
        end else if (start_ok_s) begin
            hr_rel_r  <= hr;
            min_rel_r <= min;
            sec_rel_r <= sec;
        end else begin
            hr_rel_r  <= hr_rel_r;
            min_rel_r <= min_rel_r;
            sec_rel_r <= sec_rel_r;
        end
    end

    assign load_s     = expire_s;
    assign hr_load_s  = hr_rel_r;
    assign min_load_s = min_rel_r;
    assign sec_load_s = sec_rel_r;
`else
    assign load_s     = 1'b0;
    assign hr_load_s  = 5'd0;
    assign min_load_s = 6'd0;
    assign sec_load_s = 6'd0;
`endif

    crono_field #(.WIDTH(5), .MAX(HR_MAX), .WRAP(WRAP_ADJ)) u_hr (
        .clk        (clk),
        .rst        (rst),
        .inc        (adj_en_s && field_hit(sel, FIELD_HR) && inc),
        .dec        (adj_en_s && field_hit(sel, FIELD_HR) && dec),
        .borrow_in  (min_borrow_s),
        .load       (load_s),
        .load_value (hr_load_s),
        .value      (hr),
        .is_zero    (hr_zero_s),
        .borrow_out (hr_borrow_s)
    );

    crono_field #(.WIDTH(6), .MAX(MIN_MAX), .WRAP(WRAP_ADJ)) u_min (
        .clk        (clk),
        .rst        (rst),
        .inc        (adj_en_s && field_hit(sel, FIELD_MIN) && inc),
        .dec        (adj_en_s && field_hit(sel, FIELD_MIN) && dec),
        .borrow_in  (sec_borrow_s),
        .load       (load_s),
        .load_value (min_load_s),
        .value      (min),
        .is_zero    (min_zero_s),
        .borrow_out (min_borrow_s)
    );

    crono_field #(.WIDTH(6), .MAX(SEC_MAX), .WRAP(WRAP_ADJ)) u_sec (
        .clk        (clk),
        .rst        (rst),
        .inc        (adj_en_s && field_hit(sel, FIELD_SEC) && inc),
        .dec        (adj_en_s && field_hit(sel, FIELD_SEC) && dec),
        .borrow_in  (tick_step_s),
        .load       (load_s),
        .load_value (sec_load_s),
        .value      (sec),
        .is_zero    (sec_zero_s),
        .borrow_out (sec_borrow_s)
    );

    // Next-state logic; an hour borrow means RUN was entered at 00:00:00, so fall back to SET.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SET: begin
                if (start_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_SET;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next_s = ST_SET;
                end else if (expire_s) begin
`ifdef CRONO_AUTORELOAD_EN
                    state_next_s = ST_RUN;
`else
                    state_next_s = ST_EXPIRED;
`endif
                end else if (hr_borrow_s) begin
                    state_next_s = ST_SET;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (start || stop || inc || dec) begin
                    state_next_s = ST_SET;
                end else begin
                    state_next_s = ST_EXPIRED;
                end
            end
            default: begin
                state_next_s = ST_SET;
            end
        endcase
    end

    // State and status output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_SET;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s == ST_RUN);
            done_r    <= expire_s;
            alarm_r   <= (state_next_s == ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_crono_countdown_timer.sv
// Self-checking bench: a wrapping default-size timer and a saturating small timer
// driven in parallel, checked against a total-seconds reference model.
module tb_crono_countdown_timer;

`ifdef CRONO_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif
    localparam int M_SET = 0;
    localparam int M_RUN = 1;
    localparam int M_EXP = 2;

    logic       clk;
    logic       rst_i, inc_i, dec_i, start_i, stop_i, tick_i;
    logic [1:0] sel_i;

    logic [4:0] w_hr, s_hr;
    logic [5:0] w_min, w_sec, s_min, s_sec;
    logic       w_run, w_done, w_alarm, s_run, s_done, s_alarm;

    int n_checks = 0;
    int n_pass   = 0;

    int mx[2][3];
    bit wr[2];
    int fv[2][3];
    int mode[2];
    int rel[2];
    bit mdone[2];

    crono_countdown_timer dut_wrap (
        .clk(clk), .rst(rst_i), .sel(sel_i), .inc(inc_i), .dec(dec_i),
        .start(start_i), .stop(stop_i), .tick(tick_i),
        .hr(w_hr), .min(w_min), .sec(w_sec),
        .running(w_run), .done(w_done), .alarm(w_alarm)
    );

    crono_countdown_timer #(.HR_MAX(2), .MIN_MAX(3), .SEC_MAX(59), .WRAP_ADJ(1'b0)) dut_sat (
        .clk(clk), .rst(rst_i), .sel(sel_i), .inc(inc_i), .dec(dec_i),
        .start(start_i), .stop(stop_i), .tick(tick_i),
        .hr(s_hr), .min(s_min), .sec(s_sec),
        .running(s_run), .done(s_done), .alarm(s_alarm)
    );

    always #5 clk = ~clk;

    function automatic int tot(int k);
        return (fv[k][0] * (mx[k][1] + 1) + fv[k][1]) * (mx[k][2] + 1) + fv[k][2];
    endfunction

    function automatic void put(int k, int t);
        fv[k][2] = t % (mx[k][2] + 1);
        t        = t / (mx[k][2] + 1);
        fv[k][1] = t % (mx[k][1] + 1);
        fv[k][0] = t / (mx[k][1] + 1);
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            mdone[k] = 1'b0;
            if (rst_i) begin
                fv[k][0] = 0; fv[k][1] = 0; fv[k][2] = 0;
                mode[k] = M_SET;
                rel[k]  = 0;
            end else if (mode[k] == M_SET) begin
                if (start_i && tot(k) != 0) begin
                    mode[k] = M_RUN;
                    rel[k]  = tot(k);
                end else if (sel_i != 2'd3 && (inc_i || dec_i)) begin
                    int f;
                    int v;
                    f = int'(sel_i);
                    v = fv[k][f];
                    if (inc_i) v = (v == mx[k][f]) ? (wr[k] ? 0 : mx[k][f]) : v + 1;
                    else       v = (v == 0) ? (wr[k] ? mx[k][f] : 0) : v - 1;
                    fv[k][f] = v;
                end
            end else if (mode[k] == M_RUN) begin
                if (stop_i) begin
                    mode[k] = M_SET;
                end else if (tick_i) begin
                    int t;
                    t = tot(k) - 1;
                    put(k, t);
                    if (t == 0) begin
                        mdone[k] = 1'b1;
                        if (AUTORELOAD) put(k, rel[k]);
                        else            mode[k] = M_EXP;
                    end
                end
            end else begin
                if (start_i || stop_i || inc_i || dec_i) mode[k] = M_SET;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        rst_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; tick_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        n_checks++;
        if ({w_hr, w_min, w_sec, w_run, w_done, w_alarm} !== 20'd0)
            $display("FAIL reset_wrap got %0d:%0d:%0d r%b d%b a%b want all zero", w_hr, w_min, w_sec, w_run, w_done, w_alarm);
        else n_pass++;
        n_checks++;
        if ({s_hr, s_min, s_sec, s_run, s_done, s_alarm} !== 20'd0)
            $display("FAIL reset_sat got %0d:%0d:%0d r%b d%b a%b want all zero", s_hr, s_min, s_sec, s_run, s_done, s_alarm);
        else n_pass++;
    endtask

    task automatic test_adjust_hours();
        rst_i = 1'b1; step();
        sel_i = 2'd0;
        for (int i = 0; i < 24; i++) begin
            int ew;
            int es;
            inc_i = 1'b1; step();
            ew = (i + 1) % 24;
            es = (i + 1 > 2) ? 2 : i + 1;
            n_checks++;
            if (w_hr !== 5'(ew) || s_hr !== 5'(es))
                $display("FAIL inc_hr step %0d got wrap=%0d sat=%0d want wrap=%0d sat=%0d", i, w_hr, s_hr, ew, es);
            else n_pass++;
        end
        dec_i = 1'b1; step();
        n_checks++;
        if (w_hr !== 5'd23 || s_hr !== 5'd1)
            $display("FAIL dec_hr got wrap=%0d sat=%0d want wrap=23 sat=1", w_hr, s_hr);
        else n_pass++;
    endtask

    task automatic test_adjust_seconds();
        sel_i = 2'd2;
        dec_i = 1'b1; step();
        n_checks++;
        if (w_sec !== 6'd59 || s_sec !== 6'd0)
            $display("FAIL dec_sec_at_zero got wrap=%0d sat=%0d want wrap=59 sat=0", w_sec, s_sec);
        else n_pass++;
        for (int i = 0; i < 70; i++) begin
            int ew;
            int es;
            inc_i = 1'b1; step();
            ew = (59 + i + 1) % 60;
            es = (i + 1 > 59) ? 59 : i + 1;
            n_checks++;
            if (w_sec !== 6'(ew) || s_sec !== 6'(es))
                $display("FAIL inc_sec step %0d got wrap=%0d sat=%0d want wrap=%0d sat=%0d", i, w_sec, s_sec, ew, es);
            else n_pass++;
        end
        inc_i = 1'b1; dec_i = 1'b1; step();
        n_checks++;
        if (w_sec !== 6'd10 || s_sec !== 6'd59)
            $display("FAIL inc_dec_same_cycle got wrap=%0d sat=%0d want wrap=10 sat=59", w_sec, s_sec);
        else n_pass++;
        sel_i = 2'd3;
        inc_i = 1'b1; step();
        n_checks++;
        if (w_sec !== 6'd10 || w_hr !== 5'd23 || w_min !== 6'd0)
            $display("FAIL sel_none got %0d:%0d:%0d want 23:0:10", w_hr, w_min, w_sec);
        else n_pass++;
    endtask

    task automatic test_countdown_expiry();
        rst_i = 1'b1; step();
        sel_i = 2'd1; inc_i = 1'b1; step();
        sel_i = 2'd3; start_i = 1'b1; step();
        n_checks++;
        if (w_run !== 1'b1 || {w_hr, w_min, w_sec} !== {5'd0, 6'd1, 6'd0})
            $display("FAIL start_run got r%b %0d:%0d:%0d want r1 0:1:0", w_run, w_hr, w_min, w_sec);
        else n_pass++;
        tick_i = 1'b1; step();
        n_checks++;
        if ({w_hr, w_min, w_sec} !== {5'd0, 6'd0, 6'd59} || {s_hr, s_min, s_sec} !== {5'd0, 6'd0, 6'd59})
            $display("FAIL first_tick got %0d:%0d:%0d / %0d:%0d:%0d want 0:0:59", w_hr, w_min, w_sec, s_hr, s_min, s_sec);
        else n_pass++;
        for (int i = 0; i < 58; i++) begin
            tick_i = 1'b1; step();
        end
        n_checks++;
        if (w_sec !== 6'd1 || w_done !== 1'b0 || w_run !== 1'b1)
            $display("FAIL before_expiry got sec=%0d done=%b run=%b want sec=1 done=0 run=1", w_sec, w_done, w_run);
        else n_pass++;
        tick_i = 1'b1; step();
        begin
            logic [5:0] emin;
            emin = AUTORELOAD ? 6'd1 : 6'd0;
            n_checks++;
            if ({w_hr, w_min, w_sec} !== {5'd0, emin, 6'd0} || w_done !== 1'b1 || w_run !== AUTORELOAD || w_alarm !== !AUTORELOAD)
                $display("FAIL expiry got %0d:%0d:%0d d%b r%b a%b want 0:%0d:0 d1 r%b a%b",
                         w_hr, w_min, w_sec, w_done, w_run, w_alarm, emin, AUTORELOAD, !AUTORELOAD);
            else n_pass++;
        end
        step();
        n_checks++;
        if (w_done !== 1'b0 || w_alarm !== !AUTORELOAD)
            $display("FAIL done_one_cycle got done=%b alarm=%b want done=0 alarm=%b", w_done, w_alarm, !AUTORELOAD);
        else n_pass++;
        stop_i = 1'b1; step();
        n_checks++;
        if (w_alarm !== 1'b0 || w_run !== 1'b0)
            $display("FAIL stop_clear got alarm=%b run=%b want alarm=0 run=0", w_alarm, w_run);
        else n_pass++;
    endtask

    task automatic test_double_borrow_pause();
        rst_i = 1'b1; step();
        sel_i = 2'd0; inc_i = 1'b1; step();
        sel_i = 2'd3; start_i = 1'b1; step();
        tick_i = 1'b1; step();
        n_checks++;
        if ({w_hr, w_min, w_sec} !== {5'd0, 6'd59, 6'd59} || {s_hr, s_min, s_sec} !== {5'd0, 6'd3, 6'd59})
            $display("FAIL double_borrow got %0d:%0d:%0d / %0d:%0d:%0d want 0:59:59 / 0:3:59", w_hr, w_min, w_sec, s_hr, s_min, s_sec);
        else n_pass++;
        stop_i = 1'b1; tick_i = 1'b1; start_i = 1'b1; step();
        n_checks++;
        if ({w_hr, w_min, w_sec} !== {5'd0, 6'd59, 6'd59} || w_run !== 1'b0)
            $display("FAIL stop_beats_tick got %0d:%0d:%0d r%b want 0:59:59 r0", w_hr, w_min, w_sec, w_run);
        else n_pass++;
        start_i = 1'b1; step();
        start_i = 1'b1; tick_i = 1'b1; step();
        sel_i = 2'd0; inc_i = 1'b1; step();
        n_checks++;
        if ({w_hr, w_min, w_sec} !== {5'd0, 6'd59, 6'd58} || w_run !== 1'b1)
            $display("FAIL resume_ignore_inc got %0d:%0d:%0d r%b want 0:59:58 r1", w_hr, w_min, w_sec, w_run);
        else n_pass++;
    endtask

    task automatic test_start_zero_and_reset();
        rst_i = 1'b1; step();
        sel_i = 2'd3; start_i = 1'b1; step();
        n_checks++;
        if (w_run !== 1'b0 || s_run !== 1'b0)
            $display("FAIL start_zero got run=%b/%b want 0/0", w_run, s_run);
        else n_pass++;
        sel_i = 2'd2;
        for (int i = 0; i < 30; i++) begin
            inc_i = 1'b1; step();
        end
        tick_i = 1'b1; step();
        n_checks++;
        if (w_sec !== 6'd30 || w_run !== 1'b0)
            $display("FAIL tick_in_set got sec=%0d run=%b want sec=30 run=0", w_sec, w_run);
        else n_pass++;
        sel_i = 2'd3; start_i = 1'b1; step();
        rst_i = 1'b1; tick_i = 1'b1; step();
        n_checks++;
        if ({w_hr, w_min, w_sec, w_run, w_done, w_alarm} !== 20'd0)
            $display("FAIL reset_midrun got %0d:%0d:%0d r%b d%b a%b want all zero", w_hr, w_min, w_sec, w_run, w_done, w_alarm);
        else n_pass++;
    endtask

    task automatic test_short_expiry();
        rst_i = 1'b1; step();
        sel_i = 2'd2;
        inc_i = 1'b1; step();
        inc_i = 1'b1; step();
        sel_i = 2'd3; start_i = 1'b1; step();
        tick_i = 1'b1; step();
        n_checks++;
        if (w_sec !== 6'd1 || w_done !== 1'b0)
            $display("FAIL short_tick1 got sec=%0d done=%b want sec=1 done=0", w_sec, w_done);
        else n_pass++;
        tick_i = 1'b1; step();
        begin
            logic [5:0] esec;
            esec = AUTORELOAD ? 6'd2 : 6'd0;
            n_checks++;
            if ({w_hr, w_min, w_sec} !== {5'd0, 6'd0, esec} || w_done !== 1'b1 || w_run !== AUTORELOAD || w_alarm !== !AUTORELOAD)
                $display("FAIL short_expiry got %0d:%0d:%0d d%b r%b a%b want 0:0:%0d d1 r%b a%b",
                         w_hr, w_min, w_sec, w_done, w_run, w_alarm, esec, AUTORELOAD, !AUTORELOAD);
            else n_pass++;
        end
        sel_i = 2'd0; inc_i = 1'b1; step();
        n_checks++;
        if (w_hr !== 5'd0 || w_alarm !== 1'b0 || w_run !== AUTORELOAD)
            $display("FAIL clear_no_adjust got hr=%0d alarm=%b run=%b want hr=0 alarm=0 run=%b", w_hr, w_alarm, w_run, AUTORELOAD);
        else n_pass++;
    endtask

    task automatic test_random();
        rst_i = 1'b1; step();
        for (int c = 0; c < 4000; c++) begin
            sel_i   = 2'($urandom_range(0, 3));
            inc_i   = ($urandom_range(0, 2) == 0);
            dec_i   = ($urandom_range(0, 3) == 0);
            start_i = ($urandom_range(0, 7) == 0);
            stop_i  = ($urandom_range(0, 24) == 0);
            tick_i  = ($urandom_range(0, 1) == 0);
            rst_i   = ($urandom_range(0, 499) == 0);
            step();
            n_checks++;
            if ({w_hr, w_min, w_sec} !== {5'(fv[0][0]), 6'(fv[0][1]), 6'(fv[0][2])} ||
                {s_hr, s_min, s_sec} !== {5'(fv[1][0]), 6'(fv[1][1]), 6'(fv[1][2])})
                $display("FAIL rand_fields cyc %0d got %0d:%0d:%0d / %0d:%0d:%0d want %0d:%0d:%0d / %0d:%0d:%0d", c,
                         w_hr, w_min, w_sec, s_hr, s_min, s_sec, fv[0][0], fv[0][1], fv[0][2], fv[1][0], fv[1][1], fv[1][2]);
            else n_pass++;
            n_checks++;
            if ({w_run, w_done, w_alarm} !== {mode[0] == M_RUN, mdone[0], mode[0] == M_EXP} ||
                {s_run, s_done, s_alarm} !== {mode[1] == M_RUN, mdone[1], mode[1] == M_EXP})
                $display("FAIL rand_status cyc %0d got %b%b%b / %b%b%b want %b%b%b / %b%b%b", c,
                         w_run, w_done, w_alarm, s_run, s_done, s_alarm,
                         mode[0] == M_RUN, mdone[0], mode[0] == M_EXP, mode[1] == M_RUN, mdone[1], mode[1] == M_EXP);
            else n_pass++;
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_i = 1'b1; sel_i = 2'd3; inc_i = 1'b0; dec_i = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; tick_i = 1'b0;
        mx[0][0] = 23; mx[0][1] = 59; mx[0][2] = 59; wr[0] = 1'b1;
        mx[1][0] = 2;  mx[1][1] = 3;  mx[1][2] = 59; wr[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fv[k][0] = 0; fv[k][1] = 0; fv[k][2] = 0;
            mode[k] = M_SET; rel[k] = 0; mdone[k] = 1'b0;
        end
        test_reset();
        test_adjust_hours();
        test_adjust_seconds();
        test_countdown_expiry();
        test_double_borrow_pause();
        test_start_zero_and_reset();
        test_short_expiry();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
